// File: rtl/timing_calc_arbiter_if.sv
// Axis request/response bus and calculator handshake around timing_calc_arbiter.
// slave is the arbiter's view; master is the axis controllers plus the calculator.
interface timing_calc_arbiter_if #(
  parameter int N_AXES = 4
);
  logic [N_AXES-1:0]    req;
  logic [N_AXES*32-1:0] req_speed;
  logic [N_AXES*32-1:0] req_acceleration;
  logic [N_AXES*32-1:0] req_jerk;
  logic [N_AXES-1:0]    grant;
  logic                 busy;
  logic                 done;
  logic [2:0]           done_axis;
  logic                 error;
  logic [0:4][31:0]     params;
  logic                 calc_start;
  logic [31:0]          calc_speed;
  logic [31:0]          calc_acceleration;
  logic [31:0]          calc_jerk;
  logic                 calc_finish;
  logic [0:4][31:0]     calc_params;

  modport master (
    output req, req_speed, req_acceleration, req_jerk, calc_finish, calc_params,
    input  grant, busy, done, done_axis, error, params,
           calc_start, calc_speed, calc_acceleration, calc_jerk
  );

  modport slave (
    input  req, req_speed, req_acceleration, req_jerk, calc_finish, calc_params,
    output grant, busy, done, done_axis, error, params,
           calc_start, calc_speed, calc_acceleration, calc_jerk
  );
endinterface

// File: rtl/timing_calc_arbiter.sv
// Round-robin share of one speed_to_timing calculator between N_AXES axis controllers.
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's operands
// WAIT  | hold calc_start until finish, operand reject or timeout
// RESP  | one-cycle done with result, then release grant
module timing_calc_arbiter #(
  parameter int N_AXES       = 4,
  parameter int CALC_TIMEOUT = 64
) (
  input logic                  clk_i,
  input logic                  reset_i,
  timing_calc_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_AXES);
  localparam int TW = $clog2(CALC_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q;
  logic [N_AXES-1:0] grant_q;
  logic [N_AXES-1:0] mask_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     win_q;
  logic [TW-1:0]     tmr_q;
  logic              done_q;
  logic              error_q;
  logic [2:0]        done_axis_q;
  logic [0:4][31:0]  params_q;
  logic              calc_start_q;
  logic [31:0]       calc_speed_q;
  logic [31:0]       calc_acc_q;
  logic [31:0]       calc_jerk_q;

  logic              found_d;
  logic [IW-1:0]     win_d;
  logic [IW-1:0]     ptr_d;
  logic [IW:0]       idx;
  logic [N_AXES-1:0] req_eff;
  logic [31:0]       speed_d;
  logic [31:0]       acc_d;
  logic [31:0]       jerk_d;

  always_comb begin
    req_eff = bus.req & ~mask_q;
    found_d = 1'b0;
    win_d   = '0;
    idx     = '0;
    for (int i = 0; i < N_AXES; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_AXES)) idx = idx - (IW+1)'(N_AXES);
      if (!found_d && req_eff[idx[IW-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx[IW-1:0];
      end
    end
    ptr_d   = (win_d == IW'(N_AXES - 1)) ? '0 : win_d + 1'b1;
    speed_d = '0;
    acc_d   = '0;
    jerk_d  = '0;
    for (int i = 0; i < N_AXES; i++) begin
      if (win_d == IW'(i)) begin
        speed_d = bus.req_speed[32*i +: 32];
        acc_d   = bus.req_acceleration[32*i +: 32];
        jerk_d  = bus.req_jerk[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      win_q        <= '0;
      tmr_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      done_axis_q  <= '0;
      params_q     <= '0;
      calc_start_q <= 1'b0;
      calc_speed_q <= '0;
      calc_acc_q   <= '0;
      calc_jerk_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mask_q <= '0;
          if (found_d) begin
            win_q          <= win_d;
            grant_q        <= '0;
            grant_q[win_d] <= 1'b1;
            ptr_q          <= ptr_d;
            calc_speed_q   <= speed_d;
            calc_acc_q     <= acc_d;
            calc_jerk_q    <= jerk_d;
            // a zero operand would divide by zero in the calculator, so never start it
            calc_start_q   <= (speed_d != '0) && (acc_d != '0) && (jerk_d != '0);
            tmr_q          <= TW'(CALC_TIMEOUT);
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!calc_start_q) begin
            error_q     <= 1'b1;
            params_q    <= '0;
            done_q      <= 1'b1;
            done_axis_q <= 3'(win_q);
            state_q     <= ST_RESP;
          end else if (bus.calc_finish) begin
            params_q     <= bus.calc_params;
            error_q      <= 1'b0;
            calc_start_q <= 1'b0;
            done_q       <= 1'b1;
            done_axis_q  <= 3'(win_q);
            state_q      <= ST_RESP;
          end else if (tmr_q == '0) begin
            params_q     <= '0;
            error_q      <= 1'b1;
            calc_start_q <= 1'b0;
            done_q       <= 1'b1;
            done_axis_q  <= 3'(win_q);
            state_q      <= ST_RESP;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_RESP: begin
          mask_q  <= grant_q;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant             = grant_q;
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = done_q;
  assign bus.done_axis         = done_axis_q;
  assign bus.error             = error_q;
  assign bus.params            = params_q;
  assign bus.calc_start        = calc_start_q;
  assign bus.calc_speed        = calc_speed_q;
  assign bus.calc_acceleration = calc_acc_q;
  assign bus.calc_jerk         = calc_jerk_q;
endmodule

// File: tb/tb_timing_calc_arbiter.sv
// Self-checking bench for timing_calc_arbiter: vector table, reset/timeout sequences, random bursts.
module tb_timing_calc_arbiter;
  localparam int NA = 4;
  localparam int TO = 64;

  typedef struct {
    int          axis;
    logic [31:0] s;
    logic [31:0] a;
    logic [31:0] j;
    bit          hang;
    bit          chg;
    bit          exp_err;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  bit          hang  = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          model_ptr = 0;
  logic [31:0] op_s [NA];
  logic [31:0] op_a [NA];
  logic [31:0] op_j [NA];
  vec_t        vecs [7];

  timing_calc_arbiter_if #(.N_AXES(NA)) bus ();

  timing_calc_arbiter #(.N_AXES(NA), .CALC_TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [0:4][31:0] calc_f(input logic [31:0] s, input logic [31:0] a,
                                              input logic [31:0] j);
    logic [0:4][31:0] r;
    r[0] = s + a;
    r[1] = a ^ j;
    r[2] = s * 32'd3;
    r[3] = j + 32'd7;
    r[4] = s - a;
    return r;
  endfunction

  // Calculator stand-in: one-edge latency, outputs cleared while start is low.
  always @(posedge clk) begin
    if (bus.calc_start === 1'b1 && !hang) begin
      bus.calc_finish <= 1'b1;
      bus.calc_params <= calc_f(bus.calc_speed, bus.calc_acceleration, bus.calc_jerk);
    end else begin
      bus.calc_finish <= 1'b0;
      bus.calc_params <= '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NA; i++) begin
      bus.req_speed[32*i +: 32]        = op_s[i];
      bus.req_acceleration[32*i +: 32] = op_a[i];
      bus.req_jerk[32*i +: 32]         = op_j[i];
    end
  endtask

  function automatic int ref_pick(input logic [NA-1:0] pend, input int ptr);
    for (int i = 0; i < NA; i++) if (pend[(ptr + i) % NA]) return (ptr + i) % NA;
    return -1;
  endfunction

  function automatic bit op_err(input int w);
    return (op_s[w] == 0) || (op_a[w] == 0) || (op_j[w] == 0);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(bus.grant), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_done_axis"}, 64'(bus.done_axis), 0);
    chk({tag, "_error"}, 64'(bus.error), 0);
    chk({tag, "_start"}, 64'(bus.calc_start), 0);
    chk({tag, "_calc_ops"}, {bus.calc_speed | bus.calc_acceleration, bus.calc_jerk}, 0);
    for (int p = 0; p < 5; p++) chk($sformatf("%s_params%0d", tag, p), 64'(bus.params[p]), 0);
  endtask

  // Single request on one axis; latency and start cycles measured from the grant.
  task automatic run_one(input vec_t v);
    int               cyc = 0;
    int               gcyc = -1;
    int               starts = 0;
    bit               got = 1'b0;
    logic [0:4][31:0] expp;
    op_s[v.axis] = v.s;
    op_a[v.axis] = v.a;
    op_j[v.axis] = v.j;
    drive_ops();
    hang = v.hang;
    expp = v.exp_err ? '0 : calc_f(v.s, v.a, v.j);
    bus.req[v.axis] = 1'b1;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus.grant != 0 && gcyc < 0) begin
        gcyc = cyc;
        chk("grant_onehot", 64'(bus.grant), 64'(1) << v.axis);
        if (v.chg) begin
          op_s[v.axis] = 32'd5000;
          drive_ops();
        end
      end
      if (bus.calc_start) starts++;
      if (bus.done) begin
        got = 1'b1;
        chk("done_axis", 64'(bus.done_axis), 64'(v.axis));
        chk("error", 64'(bus.error), 64'(v.exp_err));
        for (int p = 0; p < 5; p++) chk($sformatf("params%0d", p), 64'(bus.params[p]), 64'(expp[p]));
        chk("latency", 64'(cyc - gcyc), 64'(v.exp_lat));
        chk("start_cycles", 64'(starts), 64'(v.exp_starts));
        chk("calc_speed", 64'(bus.calc_speed), 64'(v.s));
        chk("grant_held", 64'(bus.grant), 64'(1) << v.axis);
        bus.req[v.axis] = 1'b0;
      end
    end
    chk("done_seen", 64'(got), 1);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 0);
    chk("start_low", 64'(bus.calc_start), 0);
    @(negedge clk);
    hang = 1'b0;
    model_ptr = (v.axis + 1) % NA;
  endtask

  // Several requests raised together; order and spacing come from the round-robin model.
  task automatic run_multi(input logic [NA-1:0] m, input int n, input string tag);
    int               exp_ax [$];
    logic [NA-1:0]    pend;
    int               cyc = 0;
    int               k = 0;
    int               last = 0;
    int               w;
    logic [0:4][31:0] expp;
    pend = m;
    for (int i = 0; i < n; i++) begin
      w = ref_pick(pend, model_ptr);
      exp_ax.push_back(w);
      pend[w] = 1'b0;
      model_ptr = (w + 1) % NA;
    end
    bus.req = bus.req | m;
    while (cyc < 100 * n + 10 && k < n) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        w = exp_ax[k];
        expp = op_err(w) ? '0 : calc_f(op_s[w], op_a[w], op_j[w]);
        chk({tag, "_axis"}, 64'(bus.done_axis), 64'(w));
        chk({tag, "_error"}, 64'(bus.error), 64'(op_err(w)));
        for (int p = 0; p < 5; p++)
          chk($sformatf("%s_params%0d", tag, p), 64'(bus.params[p]), 64'(expp[p]));
        if (k == 0) chk({tag, "_first_lat"}, 64'(cyc), op_err(w) ? 64'd2 : 64'd3);
        else        chk({tag, "_gap"}, 64'(cyc - last), op_err(w) ? 64'd3 : 64'd4);
        last = cyc;
        bus.req[w] = 1'b0;
        k++;
      end
    end
    chk({tag, "_served"}, 64'(k), 64'(n));
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{axis:0, s:1000, a:2000, j:100, hang:0, chg:0, exp_err:0, exp_lat:2,  exp_starts:2};
    vecs[1] = '{axis:2, s:1000, a:2000, j:0,   hang:0, chg:0, exp_err:1, exp_lat:1,  exp_starts:0};
    vecs[2] = '{axis:1, s:300,  a:40,   j:5,   hang:1, chg:0, exp_err:1, exp_lat:65, exp_starts:65};
    vecs[3] = '{axis:3, s:7,    a:9,    j:11,  hang:0, chg:0, exp_err:0, exp_lat:2,  exp_starts:2};
    vecs[4] = '{axis:0, s:1000, a:2000, j:100, hang:0, chg:1, exp_err:0, exp_lat:2,  exp_starts:2};
    vecs[5] = '{axis:1, s:0,    a:50,   j:60,  hang:0, chg:0, exp_err:1, exp_lat:1,  exp_starts:0};
    vecs[6] = '{axis:1, s:123,  a:456,  j:789, hang:0, chg:0, exp_err:0, exp_lat:2,  exp_starts:2};

    bus.req = '0;
    for (int i = 0; i < NA; i++) begin
      op_s[i] = 32'(100 * (i + 1));
      op_a[i] = 32'(20 * (i + 2));
      op_j[i] = 32'(3 * (i + 1));
    end
    drive_ops();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    model_ptr = 0;

    run_multi(4'b1111, 4, "rr");
    run_multi(4'b1001, 2, "rr2");

    foreach (vecs[i]) run_one(vecs[i]);

    op_s[1] = 32'd11; op_a[1] = 32'd22; op_j[1] = 32'd33;
    op_s[2] = 32'd44; op_a[2] = 32'd55; op_j[2] = 32'd66;
    drive_ops();
    bus.req[1] = 1'b1;
    bus.req[2] = 1'b1;
    @(negedge clk);
    chk("rst_pre_grant", 64'(bus.grant), 64'(1) << ref_pick(4'b0110, model_ptr));
    @(negedge clk);
    chk("rst_pre_start", 64'(bus.calc_start), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    @(negedge clk);
    chk("rst_no_done", 64'(bus.done), 0);
    reset = 1'b0;
    model_ptr = 0;
    run_multi(4'b0110, 2, "rst");

    for (int it = 0; it < 20; it++) begin
      logic [NA-1:0] m;
      for (int i = 0; i < NA; i++) begin
        op_s[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 99999));
        op_a[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 99999));
        op_j[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 99999));
      end
      drive_ops();
      m = NA'($urandom_range(1, 15));
      run_multi(m, $countones(m), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
